// File: rtl/regfile.sv
// 32 x 32-bit MIPS register file: two combinational read ports, one write port.
// Index 0 is hard-wired to zero; a same-cycle write is bypassed to matching reads.
module regfile #(
  parameter int REG_NUM = 32,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs_r [REG_NUM];
  logic              wr_en_s;

  assign wr_en_s = we && (waddr != {ADDR_W{1'b0}});

  // Register array: async clear, index 0 never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_en_s) begin
      regs_r[waddr] <= wdata;
    end
  end

  // Read port 1: reset, $0, bypass, array, disabled -- in that priority.
  always_comb begin
    rdata1 = {DATA_W{1'b0}};
    if (rst) begin
      rdata1 = {DATA_W{1'b0}};
    end else if (raddr1 == {ADDR_W{1'b0}}) begin
      rdata1 = {DATA_W{1'b0}};
    end else if (re1 && we && (raddr1 == waddr)) begin
      rdata1 = wdata;
    end else if (re1) begin
      rdata1 = regs_r[raddr1];
    end else begin
      rdata1 = {DATA_W{1'b0}};
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    rdata2 = {DATA_W{1'b0}};
    if (rst) begin
      rdata2 = {DATA_W{1'b0}};
    end else if (raddr2 == {ADDR_W{1'b0}}) begin
      rdata2 = {DATA_W{1'b0}};
    end else if (re2 && we && (raddr2 == waddr)) begin
      rdata2 = wdata;
    end else if (re2) begin
      rdata2 = regs_r[raddr2];
    end else begin
      rdata2 = {DATA_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed vector table, reset corner cases,
// and randomized stress against an array-based reference model.
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;

  int passed = 0;
  int total  = 0;
  logic [31:0] model [32];

  regfile dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  ra1;
    logic        re2;
    logic [4:0]  ra2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference read: priority rules evaluated on the model array.
  function automatic logic [31:0] ref_read(input logic r, input logic [4:0] ra);
    if (rst) return 32'h0;
    if (ra == 5'd0) return 32'h0;
    if (r && we && ra == waddr) return wdata;
    if (r) return model[ra];
    return 32'h0;
  endfunction

  function automatic void model_write();
    if (!rst && we && waddr != 5'd0) model[waddr] = wdata;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endfunction

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic r1, input logic [4:0] a1, input logic r2, input logic [4:0] a2);
    we = w; waddr = wa; wdata = wd; re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 5'd1,  32'h12345678, 1'b1, 5'd1,  1'b0, 5'd31, 32'h12345678, 32'h0};
    vecs[1]  = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd1,  1'b1, 5'd31, 32'h12345678, 32'hFFFFFFFF};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd1,  1'b1, 5'd31, 32'h12345678, 32'hFFFFFFFF};
    vecs[3]  = '{1'b1, 5'd0,  32'hAAAAAAAA, 1'b1, 5'd0,  1'b1, 5'd0,  32'h0,        32'h0};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b1, 5'd0,  32'h0,        32'h0};
    vecs[5]  = '{1'b1, 5'd7,  32'h1,        1'b0, 5'd7,  1'b0, 5'd7,  32'h0,        32'h0};
    vecs[6]  = '{1'b1, 5'd7,  32'h55,       1'b1, 5'd7,  1'b1, 5'd7,  32'h55,       32'h55};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b1, 5'd7,  32'h55,       32'h55};
    vecs[8]  = '{1'b1, 5'd3,  32'h99,       1'b0, 5'd3,  1'b1, 5'd3,  32'h0,        32'h99};
    vecs[9]  = '{1'b1, 5'd3,  32'h77,       1'b0, 5'd3,  1'b1, 5'd3,  32'h0,        32'h77};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  1'b0, 5'd1,  32'h77,       32'h0};

    model_clear();
    rst = 1'b1;
    drive(1'b1, 5'd4, 32'hCAFEF00D, 1'b1, 5'd4, 1'b1, 5'd9);
    #2;
    check("reset_rd1", rdata1, 32'h0);
    check("reset_rd2", rdata2, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table; each vector checked before the edge that commits it.
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].re1, vecs[i].ra1, vecs[i].re2, vecs[i].ra2);
      #2;
      check($sformatf("vec%0d_rd1", i), rdata1, vecs[i].exp1);
      check($sformatf("vec%0d_rd2", i), rdata2, vecs[i].exp2);
      model_write();
      @(negedge clk);
    end

    // Async reset mid-cycle after writing r5; a write during reset is lost.
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd1);
    #2;
    check("r5_before_rst", rdata1, 32'hDEADBEEF);
    rst = 1'b1;
    #1;
    check("r5_async_rst", rdata1, 32'h0);
    check("r1_async_rst", rdata2, 32'h0);
    drive(1'b1, 5'd5, 32'h00001234, 1'b1, 5'd5, 1'b1, 5'd5);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd1);
    #2;
    check("r5_after_rst", rdata1, 32'h0);
    check("r1_after_rst", rdata2, 32'h0);
    // First edge after release accepts a write.
    drive(1'b1, 5'd5, 32'h0BADF00D, 1'b0, 5'd0, 1'b0, 5'd0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0);
    #2;
    check("first_write_after_rst", rdata1, 32'h0BADF00D);
    model[5] = 32'h0BADF00D;
    @(negedge clk);

    // Randomized stress against the reference model.
    for (int c = 0; c < 10000; c++) begin
      logic [4:0] wa;
      rst = 1'b0;
      wa = 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), wa, $urandom(),
            1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 0) ? wa : 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 0) ? wa : 5'($urandom_range(0, 31)));
      #2;
      check("rand_rd1", rdata1, ref_read(re1, raddr1));
      check("rand_rd2", rdata2, ref_read(re2, raddr2));
      if ($urandom_range(0, 199) == 0) begin
        #1;
        rst = 1'b1;
        #1;
        check("rand_rst_rd1", rdata1, 32'h0);
        check("rand_rst_rd2", rdata2, 32'h0);
        model_clear();
      end else begin
        model_write();
      end
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regfile.md
# regfile

General-purpose register file for the five-stage MIPS core: 32 registers of 32 bits, two read ports and one write port. It is the responder to the decode stage's register-read requests (read enables plus 5-bit addresses), returning operand data in the same cycle. The write port takes results from the write-back stage. Register `$0` reads as zero and ignores writes, and a same-cycle write is forwarded to a matching read.

## Interface
- `REG_NUM`, 32, number of architectural registers (must equal 2^`ADDR_W`)
- `DATA_W`, 32, register width (`RegBus`)
- `ADDR_W`, 5, register address width (`RegAddrBus`)

- `clk`  in  1  core clock; all writes on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `we`  in  1  write enable from write-back
- `waddr`  in  `ADDR_W`  write register index
- `wdata`  in  `DATA_W`  write data
- `re1`  in  1  read enable, port 1 (decode `reg1_read_o`)
- `raddr1`  in  `ADDR_W`  read index, port 1 (decode `reg1_addr_o`)
- `rdata1`  out  `DATA_W`  read data, port 1 (decode `reg1_data_i`)
- `re2`  in  1  read enable, port 2
- `raddr2`  in  `ADDR_W`  read index, port 2
- `rdata2`  out  `DATA_W`  read data, port 2

## Operation
- Storage: `REG_NUM` × `DATA_W` array of flops; no memory macro.
- Reset (`rst`=1, asynchronous): every array entry clears to 0 immediately.
  - While `rst`=1, `rdata1` and `rdata2` are 0 regardless of other inputs.
- Write: on a rising `clk` with `rst`=0, `we`=1 and `waddr`≠0, `regs[waddr]` <= `wdata`.
  - `waddr`=0 never changes state.
  - `we`=0 changes no state.
- Read, evaluated independently per port n in priority order (combinational):
  1. `rst`=1 → 0.
  2. `raddrn`=0 → 0, even if the same cycle writes to index 0.
  3. `ren`=1, `we`=1 and `raddrn`=`waddr` → `wdata`. This is a same-cycle bypass, so write-back to decode needs no extra stall.
  4. `ren`=1 → `regs[raddrn]`.
  5. `ren`=0 → 0.
- Both ports may read the same index simultaneously; both return identical data, bypass included.
- No arithmetic; data passes unmodified at full `DATA_W`.
- The index range is exactly 0..`REG_NUM`-1, so out-of-range addresses cannot occur.

## Timing
- Read latency: 0 cycles. `rdataN` is a combinational function of the read inputs, the write inputs and the array.
- Write latency: 1 edge. Data is in the array after the rising edge and visible through path 4 from then on.
- Bypass path: `wdata` → `rdataN` is combinational within the same cycle. The team accepts this timing arc as the critical path into decode.
- Reset assertion is asynchronous: array and outputs are zero without waiting for a clock edge.
- Reset deassertion: the first write can occur on the first rising edge after `rst` falls.
- A write in flight when `rst` rises mid-cycle is lost; the array stays zero.
- There is no handshake and no back-pressure. Write and read both complete every cycle they are requested.

## Test plan
- Reset clear: write 0xDEADBEEF to r5, assert `rst` mid-cycle → `rdata1` goes to 0 immediately. After release, reading r5 returns 0.
- Write/readback: write r1=0x12345678 and r31=0xFFFFFFFF on consecutive edges. Then `re1`=1/`raddr1`=1 and `re2`=1/`raddr2`=31 → 0x12345678 and 0xFFFFFFFF.
- `$0` rules: `we`=1, `waddr`=0, `wdata`=0xAAAAAAAA. Reading index 0 on both ports, in the same cycle and the next, → 0.
- Bypass: r7 holds 0x1. In one cycle drive `we`=1, `waddr`=7, `wdata`=0x55 with `raddr1`=`raddr2`=7 and both enables set → both ports read 0x55 before the edge, and r7=0x55 after it.
- Read enable gating: r3=0x99, `re1`=0, `raddr1`=3 → `rdata1`=0. With a concurrent `we` to r3, `rdata1` is still 0.
- Random stress: 10k cycles of random `we`/`waddr`/`wdata`/`reN`/`raddrN` checked against a reference model implementing the priority rules above, with sporadic async `rst` pulses.
